// File: rtl/regfile_wb_pkg.sv
// ============================================================================
// Module   : regfile_wb_pkg
// Purpose  : Shared size encodings and write-request record for the
//            register-file writeback arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  size;
    } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous write-request FIFO with per-entry valid/address taps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  wr_req_t                   i_push_req,
    input  logic                      i_pop,
    output wr_req_t                   o_head,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [DEPTH-1:0]          o_entry_valid,
    output logic [DEPTH-1:0][4:0]     o_entry_addr
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(DEPTH);

    wr_req_t            r_mem_q [DEPTH];
    wr_req_t            r_mem_d [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr_q, r_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q, r_rd_ptr_d;
    logic [c_ptr_w:0]   r_count_q, r_count_d;
    logic [c_ptr_w-1:0] w_offset;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && (r_count_q != c_full_count);
    assign w_do_pop  = i_pop  && (r_count_q != '0);

    always_comb begin
        r_mem_d    = r_mem_q;
        r_wr_ptr_d = r_wr_ptr_q;
        r_rd_ptr_d = r_rd_ptr_q;
        r_count_d  = r_count_q;
        if (w_do_push) begin
            r_mem_d[r_wr_ptr_q] = i_push_req;
            r_wr_ptr_d          = r_wr_ptr_q + c_ptr_w'(1);
        end
        if (w_do_pop) begin
            r_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   r_count_d = r_count_q + (c_ptr_w + 1)'(1);
            2'b01:   r_count_d = r_count_q - (c_ptr_w + 1)'(1);
            default: r_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_mem_q    <= r_mem_d;
            r_wr_ptr_q <= r_wr_ptr_d;
            r_rd_ptr_q <= r_rd_ptr_d;
            r_count_q  <= r_count_d;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_offset      = '0;
        o_entry_valid = '0;
        o_entry_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offset         = c_ptr_w'(i) - r_rd_ptr_q;
            o_entry_valid[i] = ({1'b0, w_offset} < r_count_q);
            o_entry_addr[i]  = r_mem_q[i].addr;
        end
    end

    assign o_head  = r_mem_q[r_rd_ptr_q];
    assign o_count = r_count_q;

endmodule

`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
// ============================================================================
// Module   : regfile_writeback_arbiter
// Purpose  : Arbitrates ALU writeback and buffered memory returns onto the
//            single register-file write port, with starvation guard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_writeback_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int MEM_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [4:0]                        alu_addr,
    input  logic [31:0]                       alu_data,
    input  logic [1:0]                        alu_size,
    input  logic                              mem_valid,
    output logic                              mem_ready,
    input  logic [4:0]                        mem_addr,
    input  logic [31:0]                       mem_data,
    input  logic [1:0]                        mem_size,
    output logic                              write_enable,
    output logic                              write_byte_enable,
    output logic                              write_half_word_endable,
    output logic [4:0]                        write_address,
    output logic [31:0]                       write_data,
    output logic [31:0]                       pending_mask,
    output logic [$clog2(MEM_FIFO_DEPTH):0]   fifo_count
);

    localparam int c_cnt_w = $clog2(MEM_FIFO_DEPTH) + 1;
    localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_fifo_full  = c_cnt_w'(MEM_FIFO_DEPTH);
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(STARVE_LIMIT);

    logic [c_stv_w-1:0]               r_starve_q, r_starve_d;
    logic                             r_we_q, r_we_d;
    logic                             r_be_q, r_be_d;
    logic                             r_he_q, r_he_d;
    logic [4:0]                       r_addr_q, r_addr_d;
    logic [31:0]                      r_data_q, r_data_d;

    wr_req_t                          w_head;
    wr_req_t                          w_sel;
    logic [c_cnt_w-1:0]               w_count;
    logic [MEM_FIFO_DEPTH-1:0]        w_entry_valid;
    logic [MEM_FIFO_DEPTH-1:0][4:0]   w_entry_addr;
    logic                             w_fifo_empty;
    logic                             w_alu_grant;
    logic                             w_push;
    logic                             w_pop;

    assign w_fifo_empty = (w_count == '0);
    assign alu_ready    = !rst && (w_fifo_empty || (r_starve_q == c_starve_max));
    assign mem_ready    = !rst && (w_count != c_fifo_full);
    assign w_alu_grant  = alu_valid && alu_ready;
    assign w_push       = mem_valid && mem_ready;
    assign w_pop        = !w_fifo_empty && !w_alu_grant;

    wb_fifo #(
        .DEPTH (MEM_FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_push_req    ('{addr: mem_addr, data: mem_data, size: mem_size}),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_count       (w_count),
        .o_entry_valid (w_entry_valid),
        .o_entry_addr  (w_entry_addr)
    );

    always_comb begin
        r_starve_d = '0;
        if (alu_valid && !alu_ready) begin
            r_starve_d = (r_starve_q == c_starve_max) ? r_starve_q
                                                      : r_starve_q + c_stv_w'(1);
        end
    end

    // Address and data hold across idle cycles; only the enables drop.
    always_comb begin
        w_sel    = w_alu_grant ? '{addr: alu_addr, data: alu_data, size: alu_size} : w_head;
        r_we_d   = 1'b0;
        r_be_d   = 1'b0;
        r_he_d   = 1'b0;
        r_addr_d = r_addr_q;
        r_data_d = r_data_q;
        if (w_alu_grant || w_pop) begin
            r_addr_d = w_sel.addr;
            r_data_d = w_sel.data;
            r_we_d   = (w_sel.addr != 5'd0);
            case (w_sel.size)
                SZ_WORD: ;
                SZ_HALF: r_he_d = r_we_d;
                SZ_BYTE: r_be_d = r_we_d;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_q <= '0;
            r_we_q     <= 1'b0;
            r_be_q     <= 1'b0;
            r_he_q     <= 1'b0;
            r_addr_q   <= '0;
            r_data_q   <= '0;
        end else begin
            r_starve_q <= r_starve_d;
            r_we_q     <= r_we_d;
            r_be_q     <= r_be_d;
            r_he_q     <= r_he_d;
            r_addr_q   <= r_addr_d;
            r_data_q   <= r_data_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                pending_mask[w_entry_addr[i]] = 1'b1;
            end
        end
        if (r_we_q) begin
            pending_mask[r_addr_q] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    assign write_enable            = r_we_q;
    assign write_byte_enable       = r_be_q;
    assign write_half_word_endable = r_he_q;
    assign write_address           = r_addr_q;
    assign write_data              = r_data_q;
    assign fifo_count              = w_count;

    // Requesters must hold their payload while stalled.
    a_alu_stable: assert property (@(posedge clk) disable iff (rst)
        (alu_valid && !alu_ready) |=> (alu_valid && $stable({alu_addr, alu_data, alu_size})));
    a_mem_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_valid && !mem_ready) |=> (mem_valid && $stable({mem_addr, mem_data, mem_size})));

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
// ============================================================================
// Module   : tb_regfile_writeback_arbiter
// Purpose  : Directed vector bench for the register-file writeback arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic [1:0]  alu_size, mem_size;
    logic        write_enable, write_byte_enable, write_half_word_endable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_writeback_arbiter #(
        .MEM_FIFO_DEPTH (4),
        .STARVE_LIMIT   (3)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .alu_valid               (alu_valid),
        .alu_ready               (alu_ready),
        .alu_addr                (alu_addr),
        .alu_data                (alu_data),
        .alu_size                (alu_size),
        .mem_valid               (mem_valid),
        .mem_ready               (mem_ready),
        .mem_addr                (mem_addr),
        .mem_data                (mem_data),
        .mem_size                (mem_size),
        .write_enable            (write_enable),
        .write_byte_enable       (write_byte_enable),
        .write_half_word_endable (write_half_word_endable),
        .write_address           (write_address),
        .write_data              (write_data),
        .pending_mask            (pending_mask),
        .fifo_count              (fifo_count)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic [1:0]  as;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [1:0]  ms;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic        e_be;
        logic        e_he;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_pm;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] aa,
                         input logic [31:0] ad, input logic [1:0] as,
                         input logic mv, input logic [4:0] ma,
                         input logic [31:0] md, input logic [1:0] ms);
        rst       = r;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        alu_size  = as;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        mem_size  = ms;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rst av aa ad as mv ma md ms | ar mr we be he wa wd pm cnt
        vecs[0]  = '{1,0,0,0,0,            0,0,0,0,     0,0,0,0,0,0,0,0,0};
        vecs[1]  = '{0,1,5,32'hDEADBEEF,0, 0,0,0,0,     1,1,0,0,0,0,0,0,0};
        vecs[2]  = '{0,0,0,0,0,            0,0,0,0,     1,1,1,0,0,5,32'hDEADBEEF,32'h20,0};
        vecs[3]  = '{0,0,0,0,0,            1,7,32'h12,2, 1,1,0,0,0,5,32'hDEADBEEF,0,0};
        vecs[4]  = '{0,0,0,0,0,            0,0,0,0,     0,1,0,0,0,5,32'hDEADBEEF,32'h80,1};
        vecs[5]  = '{0,0,0,0,0,            0,0,0,0,     1,1,1,1,0,7,32'h12,32'h80,0};
        vecs[6]  = '{0,1,0,32'h55,1,       0,0,0,0,     1,1,0,0,0,7,32'h12,0,0};
        vecs[7]  = '{0,0,0,0,0,            1,0,32'h66,1, 1,1,0,0,0,0,32'h55,0,0};
        vecs[8]  = '{0,0,0,0,0,            0,0,0,0,     0,1,0,0,0,0,32'h55,0,1};
        vecs[9]  = '{0,1,9,32'hA5A5,1,     0,0,0,0,     1,1,0,0,0,0,32'h66,0,0};
        vecs[10] = '{0,0,0,0,0,            0,0,0,0,     1,1,1,0,1,9,32'hA5A5,32'h200,0};
        vecs[11] = '{0,1,3,32'h33,3,       1,4,32'h44,0, 1,1,0,0,0,9,32'hA5A5,0,0};
        vecs[12] = '{0,0,0,0,0,            0,0,0,0,     0,1,1,0,0,3,32'h33,32'h18,1};
        vecs[13] = '{0,0,0,0,0,            0,0,0,0,     1,1,1,0,0,4,32'h44,32'h10,0};
        vecs[14] = '{0,0,0,0,0,            0,0,0,0,     1,1,0,0,0,4,32'h44,0,0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].as,
                  vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].ms);
            #1;
            chk($sformatf("v%0d alu_ready", i),  alu_ready,               vecs[i].e_ar);
            chk($sformatf("v%0d mem_ready", i),  mem_ready,               vecs[i].e_mr);
            chk($sformatf("v%0d we", i),         write_enable,            vecs[i].e_we);
            chk($sformatf("v%0d byte_en", i),    write_byte_enable,       vecs[i].e_be);
            chk($sformatf("v%0d half_en", i),    write_half_word_endable, vecs[i].e_he);
            chk($sformatf("v%0d waddr", i),      write_address,           vecs[i].e_wa);
            chk($sformatf("v%0d wdata", i),      write_data,              vecs[i].e_wd);
            chk($sformatf("v%0d pmask", i),      pending_mask,            vecs[i].e_pm);
            chk($sformatf("v%0d fifo_count", i), fifo_count,              vecs[i].e_cnt);
            next_cycle();
        end

        // Both requesters saturate: ALU wins once every four cycles, FIFO creeps up to full.
        begin
            logic       exp_ar  [15] = '{1,0,0,0,1,0,0,0,1,0,0,0,1,0,0};
            logic       exp_mr  [15] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0,1};
            logic [2:0] exp_cnt [15] = '{0,1,1,1,1,2,2,2,2,3,3,3,3,4,3};
            logic       exp_we  [15] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
            logic [4:0] exp_wa  [15] = '{4,10,12,12,12,10,12,12,12,10,12,12,12,10,12};
            for (int c = 0; c < 15; c++) begin
                drive(0, 1, 10, 32'hA0, 0, 1, 12, 32'hC0, 0);
                #1;
                chk($sformatf("sat c%0d alu_ready", c),  alu_ready,     exp_ar[c]);
                chk($sformatf("sat c%0d mem_ready", c),  mem_ready,     exp_mr[c]);
                chk($sformatf("sat c%0d fifo_count", c), fifo_count,    exp_cnt[c]);
                chk($sformatf("sat c%0d we", c),         write_enable,  exp_we[c]);
                chk($sformatf("sat c%0d waddr", c),      write_address, exp_wa[c]);
                if (c == 13) begin
                    chk("sat full pmask", pending_mask, 32'h0000_1400);
                end
                next_cycle();
            end
        end

        // Reset with three queued returns discards everything.
        drive(1, 1, 10, 32'hA0, 0, 1, 12, 32'hC0, 0);
        #1;
        chk("rst0 alu_ready",  alu_ready,    1'b0);
        chk("rst0 mem_ready",  mem_ready,    1'b0);
        chk("rst0 fifo_count", fifo_count,   3'd3);
        chk("rst0 pmask",      pending_mask, 32'h0000_1000);
        next_cycle();
        for (int c = 1; c < 3; c++) begin
            if (c == 2) begin
                drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            #1;
            chk($sformatf("rst%0d alu_ready", c),  alu_ready,     1'b0);
            chk($sformatf("rst%0d mem_ready", c),  mem_ready,     1'b0);
            chk($sformatf("rst%0d fifo_count", c), fifo_count,    3'd0);
            chk($sformatf("rst%0d pmask", c),      pending_mask,  32'h0);
            chk($sformatf("rst%0d we", c),         write_enable,  1'b0);
            chk($sformatf("rst%0d waddr", c),      write_address, 5'd0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post-rst alu_ready",  alu_ready,    1'b1);
        chk("post-rst mem_ready",  mem_ready,    1'b1);
        chk("post-rst fifo_count", fifo_count,   3'd0);
        chk("post-rst we",         write_enable, 1'b0);
        chk("post-rst pmask",      pending_mask, 32'h0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Shares the register file's single write port between two requesters: the ALU pipeline writeback (fixed latency) and the memristor memory / in-memory-compute load return (variable latency).
- Memory returns are buffered in a small FIFO. A starvation counter guarantees ALU progress.
- Outputs drive the register file write port (write_enable, byte/half-word enables, address, data) directly.
- A pending-write mask is exported so the hazard unit can stall readers of registers with outstanding writes.

Parameters:
MEM_FIFO_DEPTH, 4, memory-return buffer entries (power of two, >=2)
STARVE_LIMIT, 3, consecutive denied ALU cycles before ALU is forced ahead of the FIFO

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle when alu_valid=1
alu_addr  input  5  destination register
alu_data  input  32  write data
alu_size  input  2  00 word, 01 half, 10 byte, 11 treated as word
mem_valid  input  1  memory return request
mem_ready  output  1  FIFO can accept
mem_addr  input  5  destination register
mem_data  input  32  write data
mem_size  input  2  same encoding as alu_size
write_enable  output  1  to register file
write_byte_enable  output  1  to register file
write_half_word_endable  output  1  to register file
write_address  output  5  to register file
write_data  output  32  to register file
pending_mask  output  32  bit i=1: write to reg i is queued or in the output stage
fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at clk edge): FIFO emptied, starve counter 0, all registered outputs 0. While rst is high, alu_ready=0 and mem_ready=0. Reset mid-operation discards queued writes with no partial write.
- mem_ready = (fifo_count < MEM_FIFO_DEPTH), combinational from state only.
  - Push occurs on mem_valid && mem_ready.
  - There is no full-bypass on a same-cycle pop.
  - Push and pop in the same cycle leave the count unchanged.
- Arbitration is evaluated every cycle.
  - FIFO head has default priority.
  - ALU is granted when the FIFO is empty, or when starve == STARVE_LIMIT.
  - alu_ready = (fifo_count==0) || (starve==STARVE_LIMIT). It does not depend on alu_valid.
  - The FIFO head pops only when non-empty and the ALU is not granted.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, when alu_valid && !alu_ready.
  - Clears on an ALU handshake or when alu_valid=0.
- Output stage is registered. A grant at cycle N produces write_enable=1 at cycle N+1, and the register file commits at the edge ending N+1.
  - ALU latency is 1 cycle.
  - Minimum memory latency is 2 cycles: push at N, visible as head at N+1, output at N+2. There is no empty-FIFO bypass.
- Size decode at output load:
  - 10 → write_byte_enable=1.
  - 01 → write_half_word_endable=1.
  - Otherwise both 0.
  - Never both 1.
- Address 0: the request is consumed normally, but the output cycle has write_enable=0 and both size enables 0.
- Idle cycle (no grant): write_enable and the size enables go to 0; write_address and write_data hold their previous values.
- pending_mask = OR of one-hot(addr) over valid FIFO entries, OR one-hot(write_address) when write_enable=1. Bit 0 is always 0. Combinational from state.
- Ordering:
  - Memory returns commit in arrival order.
  - Between requesters there is no ordering guarantee; the hazard unit uses pending_mask to enforce ordering.
- alu_* and mem_* inputs must be stable while valid && !ready. This is a protocol assumption, checked by an assertion.

Decomposition:
- Package regfile_wb_pkg:
  - size encoding constants SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10
  - packed write-request struct {addr[4:0], data[31:0], size[1:0]}
- Sub-module wb_fifo: synchronous FIFO with one push and one pop port, count output, and exposed per-entry valid/addr for the mask.

Test Plan:
- ALU only, alu_valid with addr=5, data=0xDEADBEEF, size=00 → alu_ready=1; next cycle write_enable=1, write_address=5, write_data=0xDEADBEEF, pending_mask=0x20.
- Memory push of addr=7, size=10, data=0x12 → mem_ready=1; 2 cycles later write_enable=1 and write_byte_enable=1; pending_mask bit 7 set during the 2 intervening cycles.
- Fill the FIFO with 4 memory returns and no pops (hold ALU starved) → fifo_count=4, mem_ready=0, further pushes ignored.
- FIFO non-empty and ALU continuously valid → alu_ready=0 for 3 cycles, 1 on the 4th; counter clears; FIFO then resumes draining.
- Write to addr 0 from either source → consumed, write_enable stays 0, pending_mask stays 0.
- rst asserted with 3 FIFO entries → next cycle fifo_count=0, pending_mask=0, write_enable=0, ready outputs 0 until rst deasserts.
